// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-ported data memory.
// Round-robin with a bounded hold so a streaming master cannot starve the other.
module dmem_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_we,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_we,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t          owner_reg;
    owner_t          winner;
    logic [HW-1:0]   hold_cnt_reg;
    logic [HW-1:0]   hold_cnt_next;
    logic            prio_reg;      // 0: m0 wins a tie, 1: m1 wins a tie
    logic            prio_next;
    logic            hold_full;
    logic            m0_rvalid_reg;
    logic            m1_rvalid_reg;

    assign hold_full = (hold_cnt_reg >= HW'(MAX_HOLD));

    // Winner selection and next-state computation
    always_comb begin
        winner        = OWN_NONE;
        hold_cnt_next = '0;
        prio_next     = prio_reg;

        if (owner_reg == OWN_M0 && m0_req && (!m1_req || !hold_full)) begin
            winner = OWN_M0;
        end else if (owner_reg == OWN_M1 && m1_req && (!m0_req || !hold_full)) begin
            winner = OWN_M1;
        end else if (owner_reg == OWN_M0 && m1_req) begin
            winner = OWN_M1;
        end else if (owner_reg == OWN_M1 && m0_req) begin
            winner = OWN_M0;
        end else if (m0_req && !m1_req) begin
            winner = OWN_M0;
        end else if (m1_req && !m0_req) begin
            winner = OWN_M1;
        end else if (m0_req && m1_req) begin
            winner = prio_reg ? OWN_M1 : OWN_M0;
        end

        if (winner == OWN_NONE) begin
            hold_cnt_next = '0;
        end else if (winner == owner_reg) begin
            hold_cnt_next = hold_full ? hold_cnt_reg : hold_cnt_reg + HW'(1);
        end else begin
            hold_cnt_next = HW'(1);
        end

        if (winner == OWN_M0) begin
            prio_next = 1'b1;
        end else if (winner == OWN_M1) begin
            prio_next = 1'b0;
        end
    end

    // Grants are masked while reset is held so nothing reaches memory
    assign m0_gnt = !reset && (winner == OWN_M0);
    assign m1_gnt = !reset && (winner == OWN_M1);
    assign mem_en = m0_gnt || m1_gnt;

    assign mem_addr = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : '0);
    assign mem_we   = m0_gnt ? m0_we   : (m1_gnt ? m1_we   : 4'b0000);

    for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
        assign mem_wdata[gi*8 +: 8] = m0_gnt ? m0_wdata[gi*8 +: 8]
                                    : (m1_gnt ? m1_wdata[gi*8 +: 8] : 8'h00);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg     <= OWN_NONE;
            hold_cnt_reg  <= '0;
            prio_reg      <= 1'b0;
            m0_rvalid_reg <= 1'b0;
            m1_rvalid_reg <= 1'b0;
        end else begin
            owner_reg     <= winner;
            hold_cnt_reg  <= hold_cnt_next;
            prio_reg      <= prio_next;
            m0_rvalid_reg <= m0_gnt && (m0_we == 4'b0000);
            m1_rvalid_reg <= m1_gnt && (m1_we == 4'b0000);
        end
    end

    assign m0_rvalid = m0_rvalid_reg;
    assign m1_rvalid = m1_rvalid_reg;

    // Read data is broadcast; each master qualifies it with its own rvalid
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (MAX_HOLD 4 and 1) driven by
// protocol-following requesters, checked against a behavioural arbitration model.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    logic        m0_req_s [2];
    logic        m1_req_s [2];
    logic [31:0] m0_addr_s [2];
    logic [31:0] m1_addr_s [2];
    logic [31:0] m0_wdata_s [2];
    logic [31:0] m1_wdata_s [2];
    logic [3:0]  m0_we_s [2];
    logic [3:0]  m1_we_s [2];
    logic        m0_gnt_s [2];
    logic        m1_gnt_s [2];
    logic        m0_rvalid_s [2];
    logic        m1_rvalid_s [2];
    logic [31:0] m0_rdata_s [2];
    logic [31:0] m1_rdata_s [2];
    logic        mem_en_s [2];
    logic [31:0] mem_addr_s [2];
    logic [31:0] mem_wdata_s [2];
    logic [3:0]  mem_we_s [2];
    logic [31:0] mem_rdata_s [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dmem_arbiter #(
            .MAX_HOLD ((gi == 0) ? 4 : 1),
            .AW       (32),
            .DW       (32)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req_s[gi]),
            .m0_addr   (m0_addr_s[gi]),
            .m0_wdata  (m0_wdata_s[gi]),
            .m0_we     (m0_we_s[gi]),
            .m0_gnt    (m0_gnt_s[gi]),
            .m0_rvalid (m0_rvalid_s[gi]),
            .m0_rdata  (m0_rdata_s[gi]),
            .m1_req    (m1_req_s[gi]),
            .m1_addr   (m1_addr_s[gi]),
            .m1_wdata  (m1_wdata_s[gi]),
            .m1_we     (m1_we_s[gi]),
            .m1_gnt    (m1_gnt_s[gi]),
            .m1_rvalid (m1_rvalid_s[gi]),
            .m1_rdata  (m1_rdata_s[gi]),
            .mem_en    (mem_en_s[gi]),
            .mem_addr  (mem_addr_s[gi]),
            .mem_wdata (mem_wdata_s[gi]),
            .mem_we    (mem_we_s[gi]),
            .mem_rdata (mem_rdata_s[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } acc_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_t;

    acc_t acc_q0[$];
    acc_t acc_q1[$];
    rd_t  rd_q0[$];
    rd_t  rd_q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model state, one set per instance
    int          own    [2];
    int          streak [2];
    int          prio   [2];
    int          mh     [2];
    bit          pend   [2][2];
    logic [31:0] p_addr [2][2];
    logic [31:0] p_wdata[2][2];
    logic [3:0]  p_we   [2][2];
    logic [31:0] rd_pipe[2];
    bit          force_rd;
    logic [31:0] force_val;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_acc(int d, acc_t a);
        if (d == 0) acc_q0.push_back(a);
        else        acc_q1.push_back(a);
    endfunction

    function automatic void push_rd(int d, rd_t r);
        if (d == 0) rd_q0.push_back(r);
        else        rd_q1.push_back(r);
    endfunction

    function automatic bit pop_acc(int d, output acc_t a);
        a = '{port: -1, addr: '0, wdata: '0, we: '0};
        if (d == 0) begin
            if (acc_q0.size() == 0) return 1'b0;
            a = acc_q0.pop_front();
        end else begin
            if (acc_q1.size() == 0) return 1'b0;
            a = acc_q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_rd(int d, output rd_t r);
        r = '{port: -1, data: '0};
        if (d == 0) begin
            if (rd_q0.size() == 0) return 1'b0;
            r = rd_q0.pop_front();
        end else begin
            if (rd_q1.size() == 0) return 1'b0;
            r = rd_q1.pop_front();
        end
        return 1'b1;
    endfunction

    // Arbitration rules: owner keeps going until its hold budget is spent while
    // the other waits; otherwise the other port, a lone requester, or the tie winner.
    function automatic int pick(int o, bit r0, bit r1, int s, int mhx, int pr);
        bit r [2];
        r[0] = r0;
        r[1] = r1;
        if (o >= 0 && r[o] && (!r[1-o] || s < mhx)) return o;
        if (o >= 0 && r[1-o]) return 1 - o;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (r0 && r1) return pr;
        return -1;
    endfunction

    // Monitor: pop and compare whenever an instance presents a grant or read data
    always @(negedge clk) begin
        acc_t a;
        rd_t  r;
        int   gp;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                chk($sformatf("d%0d_rst_gnt", d), {m0_gnt_s[d], m1_gnt_s[d]}, 0);
                chk($sformatf("d%0d_rst_mem_en", d), mem_en_s[d], 0);
                chk($sformatf("d%0d_rst_mem_we", d), mem_we_s[d], 0);
                chk($sformatf("d%0d_rst_rvalid", d), {m0_rvalid_s[d], m1_rvalid_s[d]}, 0);
            end else begin
                chk($sformatf("d%0d_both_gnt", d), m0_gnt_s[d] & m1_gnt_s[d], 0);
                chk($sformatf("d%0d_mem_en", d), mem_en_s[d], m0_gnt_s[d] | m1_gnt_s[d]);
                if (mem_en_s[d]) begin
                    gp = m0_gnt_s[d] ? 0 : (m1_gnt_s[d] ? 1 : -1);
                    if (!pop_acc(d, a)) begin
                        chk($sformatf("d%0d_unexpected_grant_port", d), gp, 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("d%0d_gnt_port", d), gp, a.port);
                        chk($sformatf("d%0d_mem_addr", d), mem_addr_s[d], a.addr);
                        chk($sformatf("d%0d_mem_wdata", d), mem_wdata_s[d], a.wdata);
                        chk($sformatf("d%0d_mem_we", d), mem_we_s[d], a.we);
                    end
                end else begin
                    chk($sformatf("d%0d_idle_addr", d), mem_addr_s[d], 0);
                    chk($sformatf("d%0d_idle_wdata", d), mem_wdata_s[d], 0);
                    chk($sformatf("d%0d_idle_we", d), mem_we_s[d], 0);
                end
                if (m0_rvalid_s[d] || m1_rvalid_s[d]) begin
                    chk($sformatf("d%0d_both_rvalid", d), m0_rvalid_s[d] & m1_rvalid_s[d], 0);
                    gp = m0_rvalid_s[d] ? 0 : 1;
                    if (!pop_rd(d, r)) begin
                        chk($sformatf("d%0d_unexpected_rvalid_port", d), gp, 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("d%0d_rvalid_port", d), gp, r.port);
                        chk($sformatf("d%0d_m0_rdata", d), m0_rdata_s[d], r.data);
                        chk($sformatf("d%0d_m1_rdata", d), m1_rdata_s[d], r.data);
                    end
                end
            end
        end
    end

    // Preload a specific request on port p of both instances
    task automatic preset(int p, logic [31:0] addr, logic [31:0] wdata, logic [3:0] we);
        for (int d = 0; d < 2; d++) begin
            pend[d][p]    = 1'b1;
            p_addr[d][p]  = addr;
            p_wdata[d][p] = wdata;
            p_we[d][p]    = we;
        end
    endtask

    // One clock of stimulus; w0/w1 say whether each requester wants an access
    task automatic cycle(bit w0, bit w1);
        bit   want [2];
        bit   rq   [2];
        int   w;
        acc_t a;
        rd_t  r;
        want[0] = w0;
        want[1] = w1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            mem_rdata_s[d] = rd_pipe[d];
            rd_pipe[d]     = force_rd ? force_val : $urandom;
            for (int p = 0; p < 2; p++) begin
                if (!want[p]) begin
                    pend[d][p] = 1'b0;
                end else if (!pend[d][p]) begin
                    pend[d][p]    = 1'b1;
                    p_addr[d][p]  = $urandom;
                    p_wdata[d][p] = $urandom;
                    p_we[d][p]    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                end
                rq[p] = pend[d][p];
            end
            m0_req_s[d]   = rq[0];
            m0_addr_s[d]  = p_addr[d][0];
            m0_wdata_s[d] = p_wdata[d][0];
            m0_we_s[d]    = p_we[d][0];
            m1_req_s[d]   = rq[1];
            m1_addr_s[d]  = p_addr[d][1];
            m1_wdata_s[d] = p_wdata[d][1];
            m1_we_s[d]    = p_we[d][1];

            w = pick(own[d], rq[0], rq[1], streak[d], mh[d], prio[d]);
            if (w >= 0) begin
                a = '{port: w, addr: p_addr[d][w], wdata: p_wdata[d][w], we: p_we[d][w]};
                push_acc(d, a);
                if (p_we[d][w] == 4'h0) begin
                    r = '{port: w, data: rd_pipe[d]};
                    push_rd(d, r);
                end
                streak[d]  = (w == own[d]) ? ((streak[d] < mh[d]) ? streak[d] + 1 : mh[d]) : 1;
                prio[d]    = 1 - w;
                pend[d][w] = 1'b0;
            end else begin
                streak[d] = 0;
            end
            own[d] = w;
        end
        force_rd = 1'b0;
    endtask

    task automatic reset_assert();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m0_req_s[d] = 1'b0;
            m1_req_s[d] = 1'b0;
            own[d]      = -1;
            streak[d]   = 0;
            prio[d]     = 0;
            pend[d][0]  = 1'b0;
            pend[d][1]  = 1'b0;
        end
        acc_q0.delete();
        acc_q1.delete();
        rd_q0.delete();
        rd_q1.delete();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        mh[0]     = 4;
        mh[1]     = 1;
        force_rd  = 1'b0;
        force_val = '0;
        for (int d = 0; d < 2; d++) begin
            m0_addr_s[d]   = '0;
            m1_addr_s[d]   = '0;
            m0_wdata_s[d]  = '0;
            m1_wdata_s[d]  = '0;
            m0_we_s[d]     = '0;
            m1_we_s[d]     = '0;
            mem_rdata_s[d] = '0;
            rd_pipe[d]     = '0;
        end
        reset_assert();
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_reset_gnt", d), {m0_gnt_s[d], m1_gnt_s[d]}, 0);
            chk($sformatf("d%0d_reset_mem_en", d), mem_en_s[d], 0);
            chk($sformatf("d%0d_reset_rvalid", d), {m0_rvalid_s[d], m1_rvalid_s[d]}, 0);
            chk($sformatf("d%0d_reset_mem_addr", d), mem_addr_s[d], 0);
        end
        reset_release();

        // Lone m0 read of 0x10 returning 0xDEADBEEF
        preset(0, 32'h0000_0010, 32'h0, 4'b0000);
        force_rd  = 1'b1;
        force_val = 32'hDEAD_BEEF;
        cycle(1'b1, 1'b0);
        idle(3);
        reset_assert();
        reset_release();

        // Both stream from the first cycle after reset
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1);
        idle(3);
        reset_assert();
        reset_release();

        // Lone m1 byte-lane write; no rvalid may follow
        preset(1, 32'h0000_0020, 32'h0000_ABCD, 4'b0011);
        cycle(1'b0, 1'b1);
        idle(3);

        // Reset in the middle of a read grant
        preset(0, 32'h0000_0040, 32'h0, 4'b0000);
        cycle(1'b1, 1'b0);
        #2;
        reset_assert();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_midrst_gnt", d), {m0_gnt_s[d], m1_gnt_s[d]}, 0);
            chk($sformatf("d%0d_midrst_mem_en", d), mem_en_s[d], 0);
            chk($sformatf("d%0d_midrst_mem_we", d), mem_we_s[d], 0);
        end
        reset_release();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        idle(3);
        reset_assert();
        reset_release();

        // Lone m0 for 10 cycles saturates the hold counter, then m1 joins
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        idle(3);

        // Randomised traffic with withdrawals and back-to-back requests
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        idle(4);

        chk("d0_acc_left", acc_q0.size(), 0);
        chk("d1_acc_left", acc_q1.size(), 0);
        chk("d0_rd_left", rd_q0.size(), 0);
        chk("d1_rd_left", rd_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (daddr/dwdata/dwe/drdata, one-cycle synchronous read) between two requesters: port m0 (cpu load/store path, higher reset priority) and port m1 (loader/debug/DMA master).
- Single-beat accesses with a req/gnt handshake.
- Round-robin arbitration with a bounded hold, so a streaming master cannot starve the other.
- Sits between the requesters and the dmem instance.

Parameters:
- MAX_HOLD, 4, max consecutive grants to the current owner while the other port is requesting (minimum 1; 1 = strict alternation).
- AW, 32, address width.
- DW, 32, data width (byte lanes = DW/8; must be 32 here, so dwe is 4 bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 requests an access; addr/wdata/we held stable until m0_gnt.
- m0_addr  in  AW  m0 byte address.
- m0_wdata  in  DW  m0 write data, lane-aligned.
- m0_we  in  4  m0 byte-lane write enables; 0000 = read.
- m0_gnt  out  1  m0 access is presented to memory this cycle.
- m0_rvalid  out  1  m0 read data valid (cycle after a read grant).
- m0_rdata  out  DW  read data to m0.
- m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata: same as m0, for port m1.
- mem_en  out  1  memory access this cycle.
- mem_addr  out  AW  to dmem daddr.
- mem_wdata  out  DW  to dmem dwdata.
- mem_we  out  4  to dmem dwe.
- mem_rdata  in  DW  from dmem drdata, valid one cycle after a read.

Behaviour:
- Registered state: owner ∈ {NONE, M0, M1}; hold_cnt (0..MAX_HOLD, saturating); prio (tie winner when no owner continues).
- Reset (async, immediate): owner = NONE, hold_cnt = 0, prio = M0, m0_rvalid = m1_rvalid = 0.
  - While reset is high, force gnt = 0, mem_en = 0, mem_we = 0000.
  - mem_addr/mem_wdata = 0 when no grant.
- Winner selection (combinational, each cycle):
  - If owner = Mx, mx_req = 1, and (other_req = 0 or hold_cnt < MAX_HOLD): winner = Mx.
  - Else if the other port requests: winner = other.
  - Else if exactly one port requests: winner = that port.
  - Else if both request: winner = prio.
  - Else: winner = NONE.
- Grant: mx_gnt = (winner == Mx); at most one gnt high per cycle.
  - mem_en = any gnt.
  - mem_addr/wdata/we are muxed from the winner in the same cycle (zero latency).
- State update on clk:
  - owner <= winner.
  - hold_cnt <= 0 if winner = NONE; saturating hold_cnt+1 if winner = owner; else 1.
  - On any grant to Mx, prio <= the other port.
- Read return: mx_rvalid <= mx_gnt && (mx_we == 0000), registered.
  - m0_rdata = m1_rdata = mem_rdata (broadcast); consumers qualify with rvalid.
  - Write grants never produce rvalid.
- A requester completes an access in the gnt cycle. To issue back-to-back accesses it keeps req high and updates addr/we after each gnt.
- Withdrawing req before gnt is allowed; no access occurs and no state is disturbed beyond normal arbitration.
- No alignment checking; byte lanes pass through unchanged.
- Reset during a read grant: the pending rvalid is dropped and never appears.
- Lone requester: granted every cycle indefinitely; hold_cnt saturates and does not wrap.
- MAX_HOLD = 1 with both requesting continuously: strict alternation M0, M1, M0, ...

Test Plan:
1. After reset, m0 alone reads 0x0000_0010, mem_rdata = 0xDEADBEEF next cycle -> m0_gnt=1, mem_en=1, mem_we=0000, mem_addr=0x10 in cycle 1; m0_rvalid=1, m0_rdata=0xDEADBEEF in cycle 2; m1_gnt=m1_rvalid=0 throughout.
2. MAX_HOLD=4, m0 and m1 both hold req continuously from the first cycle after reset -> m0 granted cycles 1-4, m1 granted cycles 5-8, m0 granted 9-12; never both gnt.
3. MAX_HOLD=1, both request continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1.
4. m1 writes addr 0x20, wdata 0x0000_ABCD, we=0011, m0 idle -> m1_gnt=1, mem_we=0011, mem_wdata=0x0000ABCD, mem_addr=0x20; m1_rvalid stays 0 next cycle.
5. m0 read granted, reset asserted mid-cycle before the next edge -> mem_en, gnt, mem_we drop to 0 immediately; m0_rvalid remains 0; after release, a both-request tie goes to m0.
6. m0 alone requests 10 consecutive cycles, then m1 requests (MAX_HOLD=4) -> m0 granted all 10 cycles; with hold_cnt saturated at 4, m1 wins the next cycle m0 and m1 both request.
